gcd_control: RTL and testbench

Control unit for the GCD subtract/swap datapath. It sequences the datapath through load, Euclid subtract/swap iterations and completion, using the datapath's status flags B_eq_0 and A_lessThan_B. It drives Asel, Aen, Bsel and Ben directly into the datapath. The top level exposes a start/ready/done handshake, and the final GCD is read from the datapath's Result.

---
 rtl/gcd_control_if.sv | 42 ++++
 rtl/gcd_control.sv | 95 +++++++++
 tb/tb_gcd_control.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/gcd_control_if.sv
// Handshake and datapath-control bundle between the GCD controller and its surroundings.
// The slave side is the controller; the master side drives start and the datapath flags.
interface gcd_control_if #(
    parameter int iterBits = 8
);
    logic                start;
    logic                B_eq_0;
    logic                A_lessThan_B;
    logic [1:0]          Asel;
    logic                Aen;
    logic                Bsel;
    logic                Ben;
    logic                ready;
    logic                done;
    logic [iterBits-1:0] iter_count;

    modport master (
        output start,
        output B_eq_0,
        output A_lessThan_B,
        input  Asel,
        input  Aen,
        input  Bsel,
        input  Ben,
        input  ready,
        input  done,
        input  iter_count
    );

    modport slave (
        input  start,
        input  B_eq_0,
        input  A_lessThan_B,
        output Asel,
        output Aen,
        output Bsel,
        output Ben,
        output ready,
        output done,
        output iter_count
    );
endinterface

// File: rtl/gcd_control.sv
// Controller for the subtract/swap GCD datapath: load, Euclid iterations, one-cycle done.
// Datapath controls are decoded from the registered state plus the live datapath flags.
module gcd_control #(
    parameter int iterBits = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    gcd_control_if.slave  ctl
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0]          ASEL_IN   = 2'd0;
    localparam logic [1:0]          ASEL_SUB  = 2'd1;
    localparam logic [1:0]          ASEL_B    = 2'd2;
    localparam logic [iterBits-1:0] ITER_MAX  = {iterBits{1'b1}};

    state_t              state_q, state_d;
    logic [iterBits-1:0] iter_q, iter_d;

    logic [1:0] asel;
    logic       aen;
    logic       bsel;
    logic       ben;

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        asel    = ASEL_IN;
        aen     = 1'b0;
        bsel    = 1'b0;
        ben     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ctl.start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                asel    = ASEL_IN;
                aen     = 1'b1;
                bsel    = 1'b1;
                ben     = 1'b1;
                iter_d  = '0;
                state_d = CALC;
            end
            CALC: begin
                // B == 0 has priority: A already holds the result and must not move.
                if (ctl.B_eq_0) begin
                    state_d = DONE;
                end else begin
                    aen = 1'b1;
                    if (ctl.A_lessThan_B) begin
                        asel = ASEL_B;
                        ben  = 1'b1;
                    end else begin
                        asel = ASEL_SUB;
                    end
                    if (iter_q != ITER_MAX) begin
                        iter_d = iter_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    assign ctl.Asel       = asel;
    assign ctl.Aen        = aen;
    assign ctl.Bsel       = bsel;
    assign ctl.Ben        = ben;
    assign ctl.ready      = (state_q == IDLE);
    assign ctl.done       = (state_q == DONE);
    assign ctl.iter_count = iter_q;
endmodule

// File: tb/tb_gcd_control.sv
// Bench for gcd_control: a behavioural A/B datapath closes the loop around two controllers
// (8-bit and 2-bit iteration counters) run in lockstep from the same stimulus.
module tb_gcd_control;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] in_a, in_b;
    logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

    int n_vec  = 0;
    int n_miss = 0;

    gcd_control_if #(.iterBits(8)) bus0 ();
    gcd_control_if #(.iterBits(2)) bus1 ();

    gcd_control #(.iterBits(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus0)
    );

    gcd_control #(.iterBits(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus0.start        = start;
    assign bus0.B_eq_0       = (b0 == 16'd0);
    assign bus0.A_lessThan_B = (a0 < b0);
    assign bus1.start        = start;
    assign bus1.B_eq_0       = (b1 == 16'd0);
    assign bus1.A_lessThan_B = (a1 < b1);

    function automatic logic [15:0] a_mux(input logic [1:0] sel, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] ia);
        case (sel)
            2'd0:    return ia;
            2'd1:    return a - b;
            2'd2:    return b;
            default: return a;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (bus0.Aen) a0 <= a_mux(bus0.Asel, a0, b0, in_a);
        if (bus0.Ben) b0 <= bus0.Bsel ? in_b : a0;
        if (bus1.Aen) a1 <= a_mux(bus1.Asel, a1, b1, in_a);
        if (bus1.Ben) b1 <= bus1.Bsel ? in_b : a1;
    end

    typedef struct {
        int a;
        int b;
        int exp_r;
        int exp_k;
        int exp_first;   // 0 = exit, 1 = subtract, 2 = swap
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Euclid by quotients/remainders: each quotient q costs q subtract steps,
    // each return to A<B costs one swap.
    function automatic void ref_gcd(input int a_in, input int b_in,
                                    output int r, output int k, output int f);
        int a, b, t;
        a = a_in;
        b = b_in;
        k = 0;
        f = (b == 0) ? 0 : ((a < b) ? 2 : 1);
        while (b != 0) begin
            if (a < b) begin
                t = a; a = b; b = t;
                k++;
            end else begin
                k += a / b;
                a  = a % b;
            end
        end
        r = a;
    endfunction

    // Entered at a negedge with both controllers in IDLE; the next rising edge is the start edge.
    task automatic run_gcd(input int a, input int b, input int r, input int k, input int f,
                           input bit hold, input bit pulse, input string tag);
        int done_cyc, done_n, bad, op, res0, res1, it0, it1;
        bit load_ok, idle_ok;
        done_cyc = -1; done_n = 0; bad = 0; op = -1;
        res0 = -1; res1 = -1; it0 = -1; it1 = -1; idle_ok = 1'b0;
        in_a  = a[15:0];
        in_b  = b[15:0];
        start = 1'b1;
        @(negedge clk);
        load_ok = (bus0.Asel == 2'd0) && bus0.Aen && bus0.Bsel && bus0.Ben && !bus0.ready;
        if (!hold) start = 1'b0;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (pulse && cyc == 3) start = 1'b1;
            if (pulse && cyc == 4) start = 1'b0;
            if (bus0.Asel == 2'd3 || bus1.Asel == 2'd3 || bus0.done != bus1.done) bad++;
            if (cyc == 2) begin
                if (!bus0.Aen && !bus0.Ben) op = 0;
                else if (bus0.Aen && !bus0.Ben && bus0.Asel == 2'd1) op = 1;
                else if (bus0.Aen && bus0.Ben && bus0.Asel == 2'd2 && !bus0.Bsel) op = 2;
                else op = 3;
            end
            if (bus0.done) begin
                done_n++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    res0 = int'(a0);
                    res1 = int'(a1);
                    it0  = int'(bus0.iter_count);
                    it1  = int'(bus1.iter_count);
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                idle_ok = bus0.ready && bus1.ready;
                break;
            end
        end
        $display("run %s: A=%0d B=%0d result=%0d iters=%0d sat_iters=%0d done_cycle=%0d",
                 tag, a, b, res0, it0, it1, done_cyc);
        chk({tag, " done_cycle"}, done_cyc, k + 3);
        chk({tag, " done_pulses"}, done_n, 1);
        chk({tag, " result"}, res0, r);
        chk({tag, " result_sat"}, res1, r);
        chk({tag, " iter_count"}, it0, k);
        chk({tag, " iter_count_sat"}, it1, (k > 3) ? 3 : k);
        chk({tag, " load_outputs"}, int'(load_ok), 1);
        chk({tag, " first_calc_op"}, op, f);
        chk({tag, " illegal_cycles"}, bad, 0);
        chk({tag, " idle_after_done"}, int'(idle_ok), 1);
    endtask

    vec_t vecs[6];

    initial begin
        int r, k, f, ra, rb, spurious;

        vecs[0] = '{a: 6,  b: 3,  exp_r: 3, exp_k: 3,  exp_first: 1};
        vecs[1] = '{a: 9,  b: 0,  exp_r: 9, exp_k: 0,  exp_first: 0};
        vecs[2] = '{a: 0,  b: 7,  exp_r: 7, exp_k: 1,  exp_first: 2};
        vecs[3] = '{a: 4,  b: 10, exp_r: 2, exp_k: 7,  exp_first: 2};
        vecs[4] = '{a: 0,  b: 0,  exp_r: 0, exp_k: 0,  exp_first: 0};
        vecs[5] = '{a: 20, b: 1,  exp_r: 1, exp_k: 21, exp_first: 1};

        // Reset held for two edges with start asserted.
        rst_n = 1'b0; start = 1'b1; in_a = 16'd6; in_b = 16'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready", int'(bus0.ready), 1);
        chk("reset done", int'(bus0.done), 0);
        chk("reset enables", int'({bus0.Aen, bus0.Ben}), 0);
        chk("reset selects", int'({bus0.Asel, bus0.Bsel}), 0);
        chk("reset iter_count", int'(bus0.iter_count), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset LOAD", int'({bus0.Aen, bus0.Ben, bus0.Bsel, bus0.ready}), 4'b1110);
        start = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset from LOAD", int'({bus0.ready, bus0.Aen, bus0.Ben}), 3'b100);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_gcd(vecs[i].a, vecs[i].b, vecs[i].exp_r, vecs[i].exp_k, vecs[i].exp_first,
                    1'b0, 1'b0, $sformatf("vec%0d", i));
        end

        // Reset asserted for one edge in the middle of CALC.
        in_a = 16'd21; in_b = 16'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midcalc reset ready", int'(bus0.ready), 1);
        chk("midcalc reset enables", int'({bus0.Aen, bus0.Ben}), 0);
        chk("midcalc reset iter_count", int'(bus0.iter_count), 0);
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus0.done || !bus0.ready) spurious++;
        end
        chk("midcalc reset no done", spurious, 0);
        run_gcd(21, 6, 3, 7, 1, 1'b0, 1'b0, "restart");

        // Back-to-back runs with start held, then a start pulse ignored during CALC.
        run_gcd(6, 3, 3, 3, 1, 1'b1, 1'b0, "held1");
        run_gcd(9, 0, 9, 0, 0, 1'b1, 1'b0, "held2");
        run_gcd(0, 7, 7, 1, 2, 1'b0, 1'b0, "held3");
        run_gcd(21, 6, 3, 7, 1, 1'b0, 1'b1, "calc_pulse");

        for (int i = 0; i < 20; i++) begin
            ra = int'($urandom_range(0, 200));
            rb = int'($urandom_range(0, 200));
            ref_gcd(ra, rb, r, k, f);
            run_gcd(ra, rb, r, k, f, 1'b0, 1'b0, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
